// File: rtl/hart_miss_queue_if.sv
// hart_miss_queue_if
//   Groups the miss-side, kill, memory refill and finish signals of the
//   per-hart miss queue.
//   slave  : seen from the queue (miss/kill/mem responses in, req/fin out).
//   master : seen from the hart controller / memory model driving the queue.
//   Signals:
//     miss_valid/miss_hstate/miss_addr/miss_ready : miss event handshake
//     kill_hstate                                 : per-hart cancel mask
//     mem_req/mem_addr/mem_ack/mem_rvalid         : refill request/response
//     fin/fin_hstate/fin_hid/fin_addr             : one-cycle finish report
//     pend_hstate                                 : harts parked on a miss
interface hart_miss_queue_if #(
    parameter int HARTS  = 4,
    parameter int ADDR_W = 32
);
    localparam int HID_W = (HARTS > 1) ? $clog2(HARTS) : 1;

    logic              miss_valid;
    logic [HARTS-1:0]  miss_hstate;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic [HARTS-1:0]  kill_hstate;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic              fin;
    logic [HARTS-1:0]  fin_hstate;
    logic [HID_W-1:0]  fin_hid;
    logic [ADDR_W-1:0] fin_addr;
    logic [HARTS-1:0]  pend_hstate;

    modport slave (
        input  miss_valid, miss_hstate, miss_addr, kill_hstate,
        input  mem_ack, mem_rvalid,
        output miss_ready, mem_req, mem_addr,
        output fin, fin_hstate, fin_hid, fin_addr, pend_hstate
    );

    modport master (
        output miss_valid, miss_hstate, miss_addr, kill_hstate,
        output mem_ack, mem_rvalid,
        input  miss_ready, mem_req, mem_addr,
        input  fin, fin_hstate, fin_hid, fin_addr, pend_hstate
    );
endinterface

// File: rtl/hart_miss_queue.sv
// hart_miss_queue
//   Accepts instruction-cache miss events tagged with a one-hot hart state,
//   queues them in a circular FIFO, issues them one at a time to the memory
//   refill interface and returns a one-cycle finish pulse per live miss.
//   Ports:
//     clk : clock
//     rst : asynchronous reset, active-low
//     bus : hart_miss_queue_if.slave (miss, kill, memory and finish signals)
module hart_miss_queue #(
    parameter int HARTS  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    hart_miss_queue_if.slave  bus
);
    localparam int HID_W = (HARTS > 1) ? $clog2(HARTS) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [HARTS-1:0]  r_q_hstate [DEPTH];
    logic [ADDR_W-1:0] r_q_addr   [DEPTH];
    logic [DEPTH-1:0]  r_q_killed;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_fin;
    logic [HARTS-1:0]  r_fin_hstate;
    logic [HID_W-1:0]  r_fin_hid;
    logic [ADDR_W-1:0] r_fin_addr;

    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic [PTR_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic [DEPTH-1:0]  w_valid;
    logic [HARTS-1:0]  w_pend;
    logic              w_onehot;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [HARTS-1:0]  w_head_hstate;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_head_killed;
    logic [HID_W-1:0]  w_head_hid;

    assign w_head_idx    = r_head[IDX_W-1:0];
    assign w_tail_idx    = r_tail[IDX_W-1:0];
    assign w_count       = r_tail - r_head;
    assign w_empty       = (r_head == r_tail);
    assign w_full        = (r_head[PTR_W-1] != r_tail[PTR_W-1]) &&
                           (w_head_idx == w_tail_idx);
    assign w_head_hstate = r_q_hstate[w_head_idx];
    assign w_head_addr   = r_q_addr[w_head_idx];
    assign w_head_killed = r_q_killed[w_head_idx];

    // An entry is live when its distance from the head is below the
    // occupancy; killed entries keep their slot but drop out of pend.
    always_comb begin
        w_valid = '0;
        w_pend  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, IDX_W'(IDX_W'(i) - w_head_idx)} < w_count);
            if (w_valid[i] && !r_q_killed[i]) begin
                w_pend = w_pend | r_q_hstate[i];
            end
        end
    end

    always_comb begin
        w_head_hid = '0;
        for (int unsigned i = 0; i < HARTS; i++) begin
            if (w_head_hstate[i]) begin
                w_head_hid = HID_W'(i);
            end
        end
    end

    assign w_onehot = (bus.miss_hstate != '0) &&
                      ((bus.miss_hstate & (bus.miss_hstate - HARTS'(1))) == '0);
    assign w_ready  = !w_full && w_onehot && ((bus.miss_hstate & w_pend) == '0);
    assign w_push   = bus.miss_valid && w_ready;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_killed) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (w_head_killed) begin
                        w_pop  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_pop  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_fin        <= 1'b0;
            r_fin_hstate <= '0;
            r_fin_hid    <= '0;
            r_fin_addr   <= '0;
        end else begin
            r_state   <= w_next;
            r_mem_req <= (w_next == S_REQ);
            if (w_next == S_REQ) begin
                r_mem_addr <= w_head_addr;
            end
            r_fin <= (w_next == S_FIN);
            if (w_next == S_FIN) begin
                r_fin_hstate <= w_head_hstate;
                r_fin_hid    <= w_head_hid;
                r_fin_addr   <= w_head_addr;
            end else begin
                r_fin_hstate <= '0;
                r_fin_hid    <= '0;
                r_fin_addr   <= '0;
            end
        end
    end

    // Kill marks only currently valid entries; the slot written by a
    // same-cycle push is not yet valid, so it always starts live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_q_killed <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_hstate[i] <= '0;
                r_q_addr[i]   <= '0;
            end
        end else begin
            r_head <= r_head + PTR_W'(w_pop);
            r_tail <= r_tail + PTR_W'(w_push);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_valid[i] && ((r_q_hstate[i] & bus.kill_hstate) != '0)) begin
                    r_q_killed[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_q_hstate[w_tail_idx] <= bus.miss_hstate;
                r_q_addr[w_tail_idx]   <= bus.miss_addr;
                r_q_killed[w_tail_idx] <= 1'b0;
            end
        end
    end

    assign bus.miss_ready  = w_ready;
    assign bus.pend_hstate = w_pend;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.fin         = r_fin;
    assign bus.fin_hstate  = r_fin_hstate;
    assign bus.fin_hid     = r_fin_hid;
    assign bus.fin_addr    = r_fin_addr;
endmodule

// File: tb/tb_hart_miss_queue.sv
// tb_hart_miss_queue
//   Drives directed scenarios and randomized traffic into hart_miss_queue and
//   compares every output each cycle against a queue-based reference model.
module tb_hart_miss_queue;
    localparam int HARTS  = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_FIN  = 3;

    logic clk;
    logic rst;

    hart_miss_queue_if #(.HARTS(HARTS), .ADDR_W(ADDR_W)) bus ();

    hart_miss_queue #(.HARTS(HARTS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driven stimulus for the current cycle.
    logic        d_valid;
    logic [3:0]  d_hs;
    logic [31:0] d_addr;
    logic [3:0]  d_kill;
    logic        d_ack;
    logic        d_rv;

    // Reference model: pending misses in arrival order plus protocol phase.
    typedef struct {
        logic [3:0]  hs;
        logic [31:0] addr;
        bit          killed;
    } ent_t;

    ent_t        mq[$];
    int          m_ph;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_fin;
    logic [3:0]  m_fhs;
    logic [1:0]  m_fhid;
    logic [31:0] m_faddr;

    function automatic logic [1:0] hid_of(input logic [3:0] hs);
        for (int i = 0; i < 4; i++) if (hs[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [3:0] model_pend();
        logic [3:0] p = '0;
        foreach (mq[i]) if (!mq[i].killed) p |= mq[i].hs;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ph = PH_IDLE;
        m_req = 0; m_addr = '0; m_fin = 0; m_fhs = '0; m_fhid = '0; m_faddr = '0;
    endtask

    task automatic drive();
        bus.miss_valid  = d_valid;
        bus.miss_hstate = d_hs;
        bus.miss_addr   = d_addr;
        bus.kill_hstate = d_kill;
        bus.mem_ack     = d_ack;
        bus.mem_rvalid  = d_rv;
    endtask

    // Compare DUT outputs with the model, then advance the model across the
    // coming clock edge using the stimulus currently driven.
    task automatic compare_and_step();
        logic [3:0] pend;
        bit         ready, accept, pop;
        int         nph;
        pend  = model_pend();
        ready = (mq.size() < DEPTH) && ($countones(d_hs) == 1) && ((d_hs & pend) == 0);
        check("miss_ready", 64'(bus.miss_ready), 64'(ready));
        check("pend_hstate", 64'(bus.pend_hstate), 64'(pend));
        check("mem_req", 64'(bus.mem_req), 64'(m_req));
        if (m_req) check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        check("fin", 64'(bus.fin), 64'(m_fin));
        check("fin_hstate", 64'(bus.fin_hstate), 64'(m_fhs));
        check("fin_hid", 64'(bus.fin_hid), 64'(m_fhid));
        if (m_fin) check("fin_addr", 64'(bus.fin_addr), 64'(m_faddr));

        accept = d_valid && ready;
        pop = 0;
        nph = m_ph;
        case (m_ph)
            PH_IDLE: if (mq.size() > 0) begin
                if (mq[0].killed) pop = 1; else nph = PH_REQ;
            end
            PH_REQ:  if (d_ack) nph = PH_WAIT;
            PH_WAIT: if (d_rv) begin
                if (mq[0].killed) begin pop = 1; nph = PH_IDLE; end
                else nph = PH_FIN;
            end
            default: begin pop = 1; nph = PH_IDLE; end
        endcase
        m_req = (nph == PH_REQ);
        if (m_req) m_addr = mq[0].addr;
        m_fin = (nph == PH_FIN);
        m_fhs   = m_fin ? mq[0].hs : 4'd0;
        m_fhid  = m_fin ? hid_of(mq[0].hs) : 2'd0;
        m_faddr = m_fin ? mq[0].addr : 32'd0;
        foreach (mq[i]) if ((mq[i].hs & d_kill) != 0) mq[i].killed = 1;
        if (pop) void'(mq.pop_front());
        if (accept) mq.push_back('{hs: d_hs, addr: d_addr, killed: 0});
        m_ph = nph;
    endtask

    task automatic cycle(input logic v, input logic [3:0] hs, input logic [31:0] a,
                         input logic [3:0] k, input logic ack, input logic rv);
        @(negedge clk);
        d_valid = v; d_hs = hs; d_addr = a; d_kill = k; d_ack = ack; d_rv = rv;
        drive();
        #1;
        compare_and_step();
    endtask

    task automatic idle(input int n, input logic ack, input logic rv);
        for (int i = 0; i < n; i++) cycle(0, 4'd0, 32'd0, 4'd0, ack, rv);
    endtask

    task automatic do_reset(input logic rv_after);
        @(negedge clk);
        rst = 0;
        d_valid = 1; d_hs = 4'b0001; d_addr = '0; d_kill = '0; d_ack = 0; d_rv = 0;
        drive();
        model_reset();
        #1;
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_fin", 64'(bus.fin), 64'd0);
        check("rst_fin_hstate", 64'(bus.fin_hstate), 64'd0);
        check("rst_fin_hid", 64'(bus.fin_hid), 64'd0);
        check("rst_fin_addr", 64'(bus.fin_addr), 64'd0);
        check("rst_pend", 64'(bus.pend_hstate), 64'd0);
        check("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        d_valid = 0;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        d_ack = rv_after; d_rv = rv_after;
        drive();
        #1;
        compare_and_step();
    endtask

    initial begin
        rst = 0;
        d_valid = 0; d_hs = '0; d_addr = '0; d_kill = '0; d_ack = 0; d_rv = 0;
        drive();
        model_reset();
        do_reset(0);

        // Single miss: ack on first request cycle, rvalid two cycles later.
        cycle(1, 4'b0010, 32'h100, 4'd0, 0, 0);
        idle(1, 0, 0);
        idle(1, 1, 0);
        idle(1, 0, 0);
        idle(1, 0, 1);
        idle(3, 0, 0);

        // Ordering and full: four harts back to back, fifth refused.
        cycle(1, 4'b0001, 32'h1000, 4'd0, 0, 0);
        cycle(1, 4'b0010, 32'h2000, 4'd0, 0, 0);
        cycle(1, 4'b0100, 32'h3000, 4'd0, 0, 0);
        cycle(1, 4'b1000, 32'h4000, 4'd0, 0, 0);
        cycle(1, 4'b0100, 32'h5000, 4'd0, 0, 0);
        idle(24, 1, 1);

        // Duplicate and malformed hart states.
        cycle(1, 4'b0100, 32'h6000, 4'd0, 0, 0);
        cycle(1, 4'b0100, 32'h6040, 4'd0, 0, 0);
        cycle(1, 4'b0011, 32'h6080, 4'd0, 0, 0);
        cycle(1, 4'b0000, 32'h60c0, 4'd0, 0, 0);
        idle(8, 1, 1);

        // Kill an in-flight miss and a queued one.
        cycle(1, 4'b0001, 32'h7000, 4'd0, 1, 0);
        cycle(1, 4'b0010, 32'h7040, 4'd0, 1, 0);
        idle(1, 1, 0);
        cycle(0, 4'd0, 32'd0, 4'b0011, 0, 0);
        idle(1, 0, 1);
        idle(1, 0, 0);
        cycle(1, 4'b0010, 32'h7080, 4'd0, 0, 0);
        idle(8, 1, 1);

        // Backpressure with stray rvalid during the request.
        cycle(1, 4'b1000, 32'h8000, 4'd0, 0, 0);
        idle(1, 0, 0);
        idle(5, 0, 1);
        idle(1, 1, 0);
        idle(1, 0, 1);
        idle(3, 0, 0);

        // Reset while waiting for refill data, then a late rvalid.
        cycle(1, 4'b0100, 32'h9000, 4'd0, 0, 0);
        idle(1, 0, 0);
        idle(1, 1, 0);
        do_reset(1);
        idle(4, 0, 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] hs, k;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       hs = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) hs = 4'd0;
            else             hs = 4'($urandom);
            k = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
            cycle(1'($urandom), hs, $urandom, k, 1'($urandom), 1'($urandom));
            if (n == 1500) do_reset(1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
